// File: rtl/bsg_loopback_node_pkg.sv
// Shared types and constants for the loopback traffic node: pattern mode,
// sequence width and backpressure LFSR tap masks.
package bsg_loopback_node_pkg;

  typedef enum logic {
    e_lb_counter     = 1'b0,
    e_lb_walking_one = 1'b1
  } lb_mode_e;

  localparam int unsigned lb_seq_width_lp = 32;

  // Right-shifting Galois tap masks; the fallback only needs a set MSB to stay nonzero.
  function automatic logic [63:0] lb_lfsr_taps(input int unsigned width);
    case (width)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_A300_0000;
      default: return (64'd1 << (width - 1)) | 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/bsg_lfsr.sv
// Free-running Galois LFSR seeded with 1; only the LSB is exported as a stall coin.
module bsg_lfsr
  import bsg_loopback_node_pkg::*;
#(
  parameter int unsigned width_p = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic lsb_o
);

  localparam logic [width_p-1:0] taps_lp = width_p'(lb_lfsr_taps(width_p));

  logic [width_p-1:0] r_state;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= width_p'(1);
    else         r_state <= (r_state >> 1) ^ (r_state[0] ? taps_lp : '0);
  end

  assign lsb_o = r_state[0];

endmodule

// File: rtl/bsg_loopback_node_gen.sv
// Combinational packet pattern generator: channel c of packet s carries
// (s+c) mod 2^cw (counter) or 1 << ((s+c) mod cw) (walking one).
module bsg_loopback_node_gen
  import bsg_loopback_node_pkg::*;
#(
  parameter int unsigned num_channels_p  = 8,
  parameter int unsigned channel_width_p = 8
) (
  input  logic [lb_seq_width_lp-1:0]                seq_i,
  input  lb_mode_e                                  mode_i,
  output logic [num_channels_p*channel_width_p-1:0] data_o
);

  for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
    logic [lb_seq_width_lp-1:0] w_sum;
    logic [lb_seq_width_lp-1:0] w_bit;

    assign w_sum = seq_i + lb_seq_width_lp'(c);
    assign w_bit = w_sum % lb_seq_width_lp'(channel_width_p);
    assign data_o[c*channel_width_p +: channel_width_p] =
      (mode_i == e_lb_counter) ? w_sum[channel_width_p-1:0]
                               : (channel_width_p'(1) << w_bit);
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO; v_i is the enqueue strobe (caller gates it with ready_o),
// yumi_i the dequeue strobe (caller gates it with v_o).
module bsg_two_fifo #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;

  assign ready_o = (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (v_i) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (v_i)    r_wptr <= ~r_wptr;
      if (yumi_i) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(v_i) - 2'(yumi_i);
    end
  end

endmodule

// File: rtl/bsg_loopback_traffic_node.sv
// Loopback traffic node: master generates, bounds and checks patterned packets;
// client echoes inbound packets through a two-entry buffer.
module bsg_loopback_traffic_node
  import bsg_loopback_node_pkg::*;
#(
  parameter int unsigned num_channels_p    = 8,
  parameter int unsigned channel_width_p   = 8,
  parameter int unsigned is_client_node_p  = 0,
  parameter int unsigned max_outstanding_p = 16,
  parameter int unsigned lfsr_width_p      = 16
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      en_i,
  input  logic                                      mode_i,
  input  logic                                      rand_stall_i,
  input  logic                                      v_i,
  input  logic [num_channels_p*channel_width_p-1:0] data_i,
  output logic                                      ready_o,
  output logic                                      v_o,
  output logic [num_channels_p*channel_width_p-1:0] data_o,
  input  logic                                      ready_i,
  output logic                                      error_o,
  output logic [31:0]                               sent_o,
  output logic [31:0]                               received_o,
  output logic                                      done_o
);

  localparam int unsigned W = num_channels_p * channel_width_p;

  logic         w_stall_bit, w_stall;
  logic         w_v, w_ready, w_send, w_recv, w_error, w_done;
  logic [W-1:0] w_data;
  logic [31:0]  r_sent, r_received;

  bsg_lfsr #(.width_p(lfsr_width_p)) stall_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .lsb_o   (w_stall_bit)
  );

  assign w_stall    = rand_stall_i & w_stall_bit;
  // Handshake outputs are forced low during reset so nothing escapes mid-reset.
  assign v_o        = ~reset_i & w_v;
  assign ready_o    = ~reset_i & w_ready;
  assign data_o     = w_data;
  assign error_o    = w_error;
  assign done_o     = w_done;
  assign sent_o     = r_sent;
  assign received_o = r_received;
  assign w_send     = v_o & ready_i;
  assign w_recv     = v_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sent     <= '0;
      r_received <= '0;
    end else begin
      if (w_send) r_sent     <= r_sent + 32'd1;
      if (w_recv) r_received <= r_received + 32'd1;
    end
  end

  if (is_client_node_p != 0) begin : g_client
    logic w_fifo_ready;

    bsg_two_fifo #(.width_p(W)) echo_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (data_i),
      .v_i     (w_recv),
      .ready_o (w_fifo_ready),
      .v_o     (w_v),
      .data_o  (w_data),
      .yumi_i  (w_send)
    );

    assign w_ready = w_fifo_ready & ~w_stall;
    assign w_error = 1'b0;
    assign w_done  = ~w_v;
  end else begin : g_master
    localparam int unsigned out_w_lp = $clog2(max_outstanding_p + 1);

    logic [out_w_lp-1:0] r_outstanding;
    lb_mode_e            r_mode;
    logic                r_held, r_error;
    logic [W-1:0]        w_expect;
    logic                w_empty;

    bsg_loopback_node_gen #(
      .num_channels_p  (num_channels_p),
      .channel_width_p (channel_width_p)
    ) tx_gen (
      .seq_i  (r_sent),
      .mode_i (r_mode),
      .data_o (w_data)
    );

    bsg_loopback_node_gen #(
      .num_channels_p  (num_channels_p),
      .channel_width_p (channel_width_p)
    ) rx_gen (
      .seq_i  (r_received),
      .mode_i (r_mode),
      .data_o (w_expect)
    );

    assign w_empty = (r_outstanding == '0);
    assign w_v     = (en_i & (r_outstanding < out_w_lp'(max_outstanding_p))) | r_held;
    assign w_ready = ~w_stall;
    assign w_error = r_error;
    assign w_done  = ~en_i & w_empty;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_outstanding <= '0;
        r_mode        <= e_lb_counter;
        r_held        <= 1'b0;
        r_error       <= 1'b0;
      end else begin
        r_held <= v_o & ~ready_i;
        if (w_send & ~w_recv)
          r_outstanding <= r_outstanding + out_w_lp'(1);
        else if (w_recv & ~w_send & ~w_empty)
          r_outstanding <= r_outstanding - out_w_lp'(1);
        if (w_recv & (w_empty | (data_i != w_expect)))
          r_error <= 1'b1;
        // A held first packet leaves outstanding at 0; keep mode so data_o stays stable.
        if (~en_i & w_empty & ~r_held)
          r_mode <= lb_mode_e'(mode_i);
      end
    end
  end

endmodule
